// File: rtl/regfile_nr_2r1w.sv
// regfile_nr_2r1w: NUM_REGS x WIDTH register file, two combinational read ports, one synchronous write port.
// Define RF_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_nr_2r1w #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [WIDTH-1:0]  ra_data,
  output logic [WIDTH-1:0]  rb_data
);
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] ra_mux, rb_mux;
  // Only in-range, non-zero-reg slots take part; unmatched addresses leave writes dropped and reads at 0.
  always_comb begin
    regs_d = regs_q;
    ra_mux = '0;
    rb_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ZERO_REG == 0 || i != 0) begin
        if (we && waddr == ADDR_W'(i)) regs_d[i] = wdata;
        if (ra_addr == ADDR_W'(i)) ra_mux = regs_q[i];
        if (rb_addr == ADDR_W'(i)) rb_mux = regs_q[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
`ifdef RF_BYPASS_EN
  logic wr_fwd;
  always_comb begin
    wr_fwd = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if ((ZERO_REG == 0 || i != 0) && waddr == ADDR_W'(i)) wr_fwd = rst_n & we;
  end
  assign ra_data = (wr_fwd && ra_addr == waddr) ? wdata : ra_mux;
  assign rb_data = (wr_fwd && rb_addr == waddr) ? wdata : rb_mux;
`else
  assign ra_data = ra_mux;
  assign rb_data = rb_mux;
`endif
endmodule

// File: tb/tb_regfile_nr_2r1w.sv
// tb_regfile_nr_2r1w: scoreboard bench over three configurations (default, zero-reg, 6 registers).
module tb_regfile_nr_2r1w;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic we = 1'b0;
  logic [2:0] waddr = '0, ra_addr = '0, rb_addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] ra0, rb0, ra1, rb1, ra2, rb2;
  logic smp = 1'b0;
  int tests = 0, fails = 0;
  typedef struct {
    string name;
    int dut;
    logic [15:0] ea;
    logic [15:0] eb;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [15:0] vals [8] = '{16'd5, 16'd29, 16'd38, 16'd51, 16'd64, 16'd82, 16'd94, 16'd112};
  logic [15:0] aa, ab;

  always #5 clk = ~clk;

  regfile_nr_2r1w #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(3), .ZERO_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra0), .rb_data(rb0));
  regfile_nr_2r1w #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(3), .ZERO_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra1), .rb_data(rb1));
  regfile_nr_2r1w #(.WIDTH(16), .NUM_REGS(6), .ADDR_W(3), .ZERO_REG(0)) u2 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra2), .rb_data(rb2));

  always @(negedge clk) begin
    if (smp) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        aa = e.dut == 0 ? ra0 : e.dut == 1 ? ra1 : ra2;
        ab = e.dut == 0 ? rb0 : e.dut == 1 ? rb1 : rb2;
        tests += 2;
        if (aa !== e.ea) begin
          fails++;
          $display("FAIL %s dut%0d ra_data=%h expected %h", e.name, e.dut, aa, e.ea);
        end
        if (ab !== e.eb) begin
          fails++;
          $display("FAIL %s dut%0d rb_data=%h expected %h", e.name, e.dut, ab, e.eb);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] a, input logic [2:0] b);
    @(posedge clk);
    #1;
    rst_n = r; we = w; waddr = wa; wdata = wd; ra_addr = a; rb_addr = b;
  endtask

  function automatic void push(input string n, input int d, input logic [15:0] ea, input logic [15:0] eb);
    q.push_back('{name: n, dut: d, ea: ea, eb: eb});
  endfunction

  task automatic chk();
    smp = 1'b1;
    @(negedge clk);
    #1;
    smp = 1'b0;
  endtask

  initial begin
    drive(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i));
      push("reset_read", 0, 16'h0, 16'h0);
      push("reset_read", 1, 16'h0, 16'h0);
      chk();
    end
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 3'(i), vals[i], 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i));
      push("sweep", 0, vals[i], vals[7 - i]);
      push("sweep_zero", 1, i == 0 ? 16'h0 : vals[i], i == 7 ? 16'h0 : vals[7 - i]);
      push("sweep_range", 2, i >= 6 ? 16'h0 : vals[i], i <= 1 ? 16'h0 : vals[7 - i]);
      chk();
    end
    drive(1'b1, 1'b1, 3'd0, 16'hBEEF, 3'd0, 3'd0);
    push("zero_wr_same", 1, 16'h0, 16'h0);
    chk();
`ifdef RF_BYPASS_EN
    drive(1'b1, 1'b1, 3'd1, 16'h1234, 3'd0, 3'd1);
    push("zero_wr1_same", 1, 16'h0, 16'h1234);
`else
    drive(1'b1, 1'b1, 3'd1, 16'h1234, 3'd0, 3'd1);
    push("zero_wr1_same", 1, 16'h0, 16'd29);
`endif
    chk();
    drive(1'b1, 1'b0, 3'd0, 16'h0, 3'd1, 3'd0);
    push("zero_after", 1, 16'h1234, 16'h0);
    chk();
    drive(1'b1, 1'b1, 3'd6, 16'hAAAA, 3'd6, 3'd5);
    push("oor_wr6", 2, 16'h0, 16'd82);
    chk();
    drive(1'b1, 1'b1, 3'd7, 16'hAAAA, 3'd7, 3'd5);
    push("oor_wr7", 2, 16'h0, 16'd82);
    chk();
    drive(1'b1, 1'b0, 3'd0, 16'h0, 3'd6, 3'd7);
    push("oor_read", 2, 16'h0, 16'h0);
    push("oor_in8", 0, 16'hAAAA, 16'hAAAA);
    chk();
    drive(1'b1, 1'b0, 3'd0, 16'h0, 3'd5, 3'd4);
    push("oor_keep5", 2, 16'd82, 16'd64);
    chk();
    drive(1'b1, 1'b1, 3'd3, 16'h0011, 3'd0, 3'd0);
    drive(1'b1, 1'b1, 3'd3, 16'h00FF, 3'd3, 3'd4);
`ifdef RF_BYPASS_EN
    push("rw_same", 0, 16'h00FF, 16'd64);
`else
    push("rw_same", 0, 16'h0011, 16'd64);
`endif
    chk();
    drive(1'b1, 1'b0, 3'd0, 16'h0, 3'd3, 3'd3);
    push("rw_after", 0, 16'h00FF, 16'h00FF);
    chk();
    drive(1'b0, 1'b1, 3'd2, 16'h5555, 3'd2, 3'd4);
    push("rst_wr_before", 0, 16'd38, 16'd64);
    chk();
    drive(1'b1, 1'b0, 3'd0, 16'h0, 3'd2, 3'd4);
    push("rst_wr_after", 0, 16'h0, 16'h0);
    push("rst_wr_after", 1, 16'h0, 16'h0);
    push("rst_wr_after", 2, 16'h0, 16'h0);
    chk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_nr_2r1w.md
Name: regfile_nr_2r1w

Overview:
- Parametrised register file that succeeds the fixed 16-bit 8:1 select mux in the single-cycle datapath.
- Provides NUM_REGS x WIDTH storage with two independent read ports (A, B) and one synchronous write port.
- Each read port is a generalised NUM_REGS:1 select mux over the stored registers.
- Feeds ALU operands and accepts writeback results in one cycle.

Parameters:
- WIDTH, 16, data width of every register and data port.
- NUM_REGS, 8, number of registers; legal range 2..256, need not be a power of 2.
- ADDR_W, 3, address width; must satisfy 2**ADDR_W >= NUM_REGS.
- ZERO_REG, 0, when 1, register 0 reads as 0 and writes to it are discarded.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  synchronous active-low reset.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- ra_addr  input  ADDR_W  read port A address.
- rb_addr  input  ADDR_W  read port B address.
- ra_data  output  WIDTH  read port A data.
- rb_data  output  WIDTH  read port B data.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low (rst_n), sampled only on the rising edge of clk.
- Reset: at a rising edge with rst_n=0, all registers clear to 0.
  - Reset beats a simultaneous write: the write is dropped.
  - ra_data and rb_data therefore read 0 from the cycle after reset.
  - Reset asserted mid-stream aborts any pending write in that cycle. No other state exists.
- Write: at a rising edge with rst_n=1 and we=1, reg[waddr] <= wdata; the new value is visible on reads after that edge.
- Write discarded (no state change) when either:
  - waddr >= NUM_REGS, or
  - ZERO_REG=1 and waddr=0.
- Read: combinational, zero latency. ra_data = reg[ra_addr] and rb_data = reg[rb_addr], each a full NUM_REGS:1 mux.
- Read forced to 0 when either:
  - address >= NUM_REGS, or
  - ZERO_REG=1 and address=0.
- Both ports may address the same register; both return the same value.
- Same-address read and write in one cycle: result depends on RF_BYPASS_EN (see below).
- No X propagation: every output bit is driven for every address value.
- Width rules: no sign or zero extension; wdata is stored verbatim, WIDTH bits.

Optional Feature:
- Macro: RF_BYPASS_EN
- Defined: write-to-read forwarding. If we=1, rst_n=1, the write is not discarded, and a read address equals waddr, that port returns wdata combinationally in the same cycle.
  - Each port forwards independently.
  - A discarded write (out of range, or zero-reg) is never forwarded.
- Undefined: no forwarding. A same-cycle read returns the old stored value; the new value appears the cycle after the write edge.

Test Plan:
- Reset then read: rst_n=0 for 1 edge, then sweep ra_addr and rb_addr over 0..7 -> all reads 0.
- Write/read sweep: write reg[i] = {5,29,38,51,64,82,94,112} for i=0..7 with ZERO_REG=0; then set ra_addr=i and rb_addr=7-i -> ra_data = value i and rb_data = value (7-i), valid with no clock edge needed.
- Zero register: ZERO_REG=1; write 0xBEEF to addr 0 -> ra_data(addr 0) = 0. Write 0x1234 to addr 1 -> reads 0x1234.
- Out of range: NUM_REGS=6, ADDR_W=3; write 0xAAAA to addr 6 and addr 7 -> no register changes; reads of 6 and 7 return 0; reg 5 keeps its prior value.
- Simultaneous read/write: reg3=0x0011; write 0x00FF to addr 3 with ra_addr=3 in the same cycle -> ra_data = 0x00FF before the edge if RF_BYPASS_EN is defined, otherwise 0x0011 before the edge and 0x00FF after it.
- Reset vs write: rst_n=0 and we=1, waddr=2, wdata=0x5555 on the same edge -> reg2 = 0 afterwards. No forwarding while rst_n=0, even with RF_BYPASS_EN.
